// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce.
// One active-low row is driven at a time. The active-low columns pass through
// a 2-FF synchroniser and are sampled at the end of each row dwell. Four row
// samples make a frame. A small FSM, stepped once per frame, debounces both
// press and release before it updates the key outputs.
module keypad_scanner #(
  parameter int SCAN_DIV       = 40000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       pressed,
  output logic       key_valid
);

  // Debounce count stores 0..DEBOUNCE_SCANS-1. The final increment is folded
  // into the accept/release decision, so the count never has to hold
  // DEBOUNCE_SCANS itself.
  localparam int DB_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [CNT_W-1:0] dwell_cnt;
  logic             tick;
  logic [1:0]       row;
  logic [1:0]       next_row;
  logic [3:0]       col_meta;
  logic [3:0]       col_sync;

  logic             row_hit;
  logic [1:0]       row_col;
  logic             acc_hit;
  logic [3:0]       acc_code;

  logic             frame_done;
  logic             frame_hit;
  logic [3:0]       frame_code;

  logic [1:0]       state;
  logic [3:0]       cand;
  logic [DB_W-1:0]  db_cnt;

  assign tick     = (dwell_cnt == DWELL_LAST);
  assign next_row = row + 2'd1;

  // Row dwell counter: counts 0..SCAN_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_cnt <= '0;
    end else if (tick) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Row driver: advance the row and its active-low one-hot drive on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row   <= 2'd0;
      row_n <= 4'b1110;
    end else if (tick) begin
      row   <= next_row;
      row_n <= ~(4'b0001 << next_row);
    end
  end

  // Two-stage synchroniser for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Row hit decode: any low column is a hit; the lowest-indexed low column wins.
  always_comb begin
    row_hit = 1'b1;
    row_col = 2'd0;
    casez (col_sync)
      4'b???0: row_col = 2'd0;
      4'b??01: row_col = 2'd1;
      4'b?011: row_col = 2'd2;
      4'b0111: row_col = 2'd3;
      default: row_hit = 1'b0;
    endcase
  end

  // The row-3 sample is merged combinationally, so the frame result is
  // available in the same cycle as the row-3 tick.
  assign frame_done = tick && (row == 2'd3);
  assign frame_hit  = acc_hit || row_hit;
  assign frame_code = acc_hit ? acc_code : {2'd3, row_col};

  // Frame accumulator: remember the first hitting row of rows 0..2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit  <= 1'b0;
      acc_code <= '0;
    end else if (tick) begin
      if (row == 2'd3) begin
        acc_hit  <= 1'b0;
        acc_code <= '0;
      end else if (!acc_hit && row_hit) begin
        acc_hit  <= 1'b1;
        acc_code <= {row, row_col};
      end
    end
  end

  // Debounce FSM, stepped once per completed frame; key_valid is a
  // one-cycle registered pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      db_cnt    <= '0;
      key       <= '0;
      pressed   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_done) begin
        case (state)
          ST_IDLE: begin
            if (frame_hit) begin
              if (DEBOUNCE_SCANS == 1) begin
                key       <= frame_code;
                pressed   <= 1'b1;
                key_valid <= 1'b1;
                db_cnt    <= '0;
                state     <= ST_HELD;
              end else begin
                cand   <= frame_code;
                db_cnt <= DB_W'(1);
                state  <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (!frame_hit) begin
              db_cnt <= '0;
              state  <= ST_IDLE;
            end else if (frame_code != cand) begin
              cand   <= frame_code;
              db_cnt <= DB_W'(1);
            end else if (db_cnt == DB_LAST) begin
              key       <= cand;
              pressed   <= 1'b1;
              key_valid <= 1'b1;
              db_cnt    <= '0;
              state     <= ST_HELD;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          ST_HELD: begin
            if (!frame_hit) begin
              if (DEBOUNCE_SCANS == 1) begin
                pressed <= 1'b0;
                db_cnt  <= '0;
                state   <= ST_IDLE;
              end else begin
                db_cnt <= DB_W'(1);
                state  <= ST_RELEASE;
              end
            end
          end
          ST_RELEASE: begin
            if (frame_hit) begin
              db_cnt <= '0;
              state  <= ST_HELD;
            end else if (db_cnt == DB_LAST) begin
              pressed <= 1'b0;
              db_cnt  <= '0;
              state   <= ST_IDLE;
            end else begin
              db_cnt <= db_cnt + DB_W'(1);
            end
          end
          default: begin
            db_cnt <= '0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-aligned stimulus for keypad_scanner with a
// behavioural keypad and a run-length debounce reference model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key;
  logic        pressed;
  logic        key_valid;
  logic [15:0] mask;

  int errors = 0;
  int checks = 0;

  // Reference model state: run-length view of the frame history.
  bit         m_held;
  bit         m_last_hit;
  int         m_last_code;
  int         m_run;
  int         m_miss;
  logic [3:0] exp_key;
  bit         exp_pressed;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key       (key),
    .pressed   (pressed),
    .key_valid (key_valid)
  );

  // Keypad matrix: a pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      if (row_n[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (mask[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_held      = 0;
    m_last_hit  = 0;
    m_last_code = 0;
    m_run       = 0;
    m_miss      = 0;
    exp_key     = '0;
    exp_pressed = 0;
  endfunction

  // One frame of the model: the frame code is simply the lowest pressed key index.
  function automatic bit model_frame(input logic [15:0] m);
    bit hit;
    int code;
    bit pulse;
    hit   = (m != 0);
    code  = 0;
    pulse = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) code = i;
    if (!m_held) begin
      if (hit) begin
        m_run = (m_last_hit && code == m_last_code) ? m_run + 1 : 1;
        if (m_run >= DB) begin
          exp_key     = 4'(code);
          exp_pressed = 1;
          pulse       = 1;
          m_held      = 1;
          m_miss      = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (hit) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss >= DB) begin
          m_held      = 0;
          exp_pressed = 0;
          m_run       = 0;
        end
      end
    end
    m_last_hit  = hit;
    m_last_code = code;
    return pulse;
  endfunction

  function automatic logic [3:0] exp_row_n(input int k);
    logic [3:0] v;
    v = 4'b1111;
    v[(k / SCAN_DIV) % 4] = 1'b0;
    return v;
  endfunction

  // Runs n clock cycles of a frame from a negedge with the given key mask, checking row drive.
  task automatic run_cycles(input logic [15:0] m, input int n, output int pulses);
    mask   = m;
    pulses = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("row_n", {28'd0, row_n}, {28'd0, exp_row_n(k)});
      if (k < FRAME) pulses += int'(key_valid);
      if (k == FRAME / 2) begin
        check("pressed_mid", {31'd0, pressed}, {31'd0, exp_pressed});
        check("key_mid", {28'd0, key}, {28'd0, exp_key});
      end
    end
  endtask

  task automatic run_frame(input logic [15:0] m);
    int pulses;
    bit pulse;
    run_cycles(m, FRAME, pulses);
    pulse = model_frame(m);
    check("kv_stray", pulses, 0);
    check("key_valid", {31'd0, key_valid}, {31'd0, pulse});
    check("key", {28'd0, key}, {28'd0, exp_key});
    check("pressed", {31'd0, pressed}, {31'd0, exp_pressed});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mask  = '0;
    #1;
    check("rst_row_n", {28'd0, row_n}, 32'he);
    check("rst_key", {28'd0, key}, 32'h0);
    check("rst_pressed", {31'd0, pressed}, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] bit_of(input int i);
    logic [15:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    int pulses;
    logic [15:0] m;
    int reps;
    rst_n = 1'b0;
    mask  = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle frame: row rotation only.
    run_frame('0);

    // Press key 9 (row 2, col 1) for three frames.
    repeat (3) run_frame(bit_of(9));
    check("key9_code", {28'd0, key}, 32'h9);

    // One-frame release, then pressed again: no drop, no pulse.
    run_frame('0);
    repeat (2) run_frame(bit_of(9));
    // Two-frame release.
    repeat (2) run_frame('0);
    check("key9_hold_code", {28'd0, key}, 32'h9);

    // Bounce: single-frame glitches never accepted.
    run_frame(bit_of(5));
    run_frame('0);
    run_frame(bit_of(6));
    run_frame('0);
    run_frame(bit_of(5));
    run_frame(bit_of(6));
    repeat (2) run_frame('0);

    // Multi-key: key 3 held, then key 12 added, then release and key 12 alone.
    repeat (2) run_frame(bit_of(3));
    repeat (2) run_frame(bit_of(3) | bit_of(12));
    repeat (2) run_frame(bit_of(12));
    repeat (2) run_frame('0);
    repeat (3) run_frame(bit_of(12));
    repeat (2) run_frame('0);

    // Reset mid-confirm: after reset, acceptance needs two full frames.
    run_frame(bit_of(7));
    do_reset();
    run_frame(bit_of(7));
    run_frame(bit_of(7));
    repeat (2) run_frame('0);

    // Reset in the middle of a frame while a key is held.
    repeat (2) run_frame(bit_of(14));
    run_cycles(bit_of(14), 7, pulses);
    do_reset();
    run_frame(bit_of(14));
    run_frame(bit_of(14));

    // Randomised frames: idle, single keys and occasional multi-key chords.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7: m = '0;
        8, 9, 10, 11, 12, 13, 14, 15, 16: m = bit_of(int'($urandom_range(0, 15)));
        default: m = 16'($urandom) | bit_of(int'($urandom_range(0, 15)));
      endcase
      reps = int'($urandom_range(1, 4));
      for (int j = 0; j < reps; j++) run_frame(m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
